// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg -- shared definitions for the load/store unit.
//   * access op-code constants carried on req_op
//   * FSM state encoding (also visible on the unit's dbg_state port)
//   * big-endian byte-lane helpers: offset 0 is bits [31:24], offset 3 is bits [7:0]
`timescale 1ns/1ps
package mips_mem_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_SW  = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_SB  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  // Extract the byte at a big-endian offset.
  function automatic logic [7:0] lane_get(input logic [31:0] word, input logic [1:0] off);
    case (off)
      2'd0:    lane_get = word[31:24];
      2'd1:    lane_get = word[23:16];
      2'd2:    lane_get = word[15:8];
      default: lane_get = word[7:0];
    endcase
  endfunction

  // Replace the byte at a big-endian offset, keeping the other three lanes.
  function automatic logic [31:0] lane_put(input logic [31:0] word, input logic [1:0] off,
                                           input logic [7:0] b);
    lane_put = word;
    case (off)
      2'd0:    lane_put[31:24] = b;
      2'd1:    lane_put[23:16] = b;
      2'd2:    lane_put[15:8]  = b;
      default: lane_put[7:0]   = b;
    endcase
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    op_legal = (op <= OP_SB);
  endfunction

  function automatic logic op_is_word(input logic [2:0] op);
    op_is_word = (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// byte_lane_merge -- combinational byte handling for the load/store unit.
// Ports:
//   word      in  32  word read from data memory
//   offset    in  2   byte offset within the word (big-endian lanes)
//   op        in  3   access op-code (selects LW / LB / LBU load formatting)
//   byte_in   in  8   store byte for SB
//   load_data out 32  formatted load result (full word, sign- or zero-extended byte)
//   merged    out 32  word with the selected lane replaced by byte_in
`timescale 1ns/1ps
module byte_lane_merge
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  op,
  input  logic [7:0]  byte_in,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0] sel;

  always_comb begin
    sel = lane_get(word, offset);
    case (op)
      OP_LB:   load_data = {{24{sel[7]}}, sel};
      OP_LBU:  load_data = {24'd0, sel};
      default: load_data = word;
    endcase
    merged = lane_put(word, offset, byte_in);
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- MEM-stage load/store unit for a word-addressed data memory.
// Handles LW/SW directly and SB as a read-modify-write of the containing word.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (see below)
//   req_op, req_addr, req_wdata access type, byte address, store data
//   resp_valid                 one-cycle completion pulse
//   resp_data, resp_err        load result (0 for stores) and error flag, held until next completion
//   stall                      pipeline hold while a presented request is not yet complete
//   memRead, memWrite          data-memory strobes (never both high)
//   address, writeData         word index and write word to data memory
//   readData                   memory read word (memory registers it on the falling edge)
//   dbg_state                  current FSM state (mips_mem_pkg::state_t encoding)
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE; the op, address and store data are registered
// on that edge, so the requester may change them freely afterwards.
`timescale 1ns/1ps
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              stall,
  output logic              memWrite,
  output logic              memRead,
  output logic [31:0]       address,
  output logic [31:0]       writeData,
  input  logic [31:0]       readData,
  output logic [2:0]        dbg_state
);

  state_t     state;
  logic [2:0] op_q;
  logic [1:0] off_q;
  logic [7:0] sb_byte_q;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        req_bad;

  assign req_ready = (state == S_IDLE);
  assign stall     = req_valid && (state != S_RESP);
  assign dbg_state = state;

  // Illegal op, or word access not on a 4-byte boundary.
  assign req_bad = !op_legal(req_op) || (op_is_word(req_op) && (req_addr[1:0] != 2'b00));

  byte_lane_merge u_lane (
    .word      (readData),
    .offset    (off_q),
    .op        (op_q),
    .byte_in   (sb_byte_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= OP_LW;
      off_q      <= 2'b00;
      sb_byte_q  <= 8'd0;
      memRead    <= 1'b0;
      memWrite   <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= 32'd0;
      address    <= 32'd0;
      writeData  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            off_q     <= req_addr[1:0];
            sb_byte_q <= req_wdata[7:0];
            address   <= 32'(req_addr[ADDR_W-1:2]);
            if (req_bad) begin
              // Errors complete next cycle without touching memory.
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= 32'd0;
            end else begin
              case (req_op)
                OP_SW: begin
                  state     <= S_WR;
                  memWrite  <= 1'b1;
                  writeData <= req_wdata;
                end
                OP_SB: begin
                  state   <= S_RMW_RD;
                  memRead <= 1'b1;
                end
                default: begin
                  state   <= S_RD;
                  memRead <= 1'b1;
                end
              endcase
            end
          end
        end
        S_RD: begin
          memRead    <= 1'b0;
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_data  <= load_data;
        end
        S_WR: begin
          memWrite   <= 1'b0;
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_data  <= 32'd0;
        end
        S_RMW_RD: begin
          // readData holds the old word here; write it back with one lane replaced.
          memRead   <= 1'b0;
          memWrite  <= 1'b1;
          writeData <= merged;
          state     <= S_RMW_WR;
        end
        S_RMW_WR: begin
          memWrite   <= 1'b0;
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_data  <= 32'd0;
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          memRead    <= 1'b0;
          memWrite   <= 1'b0;
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit -- self-checking bench for load_store_unit with a
// word-addressed data memory model (reads registered on the falling edge).
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam logic [2:0] OP_LW = 3'd0, OP_SW = 3'd1, OP_LB = 3'd2, OP_LBU = 3'd3, OP_SB = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, stall, memWrite, memRead;
  logic [31:0] resp_data, address, writeData;
  logic [31:0] readData = 32'd0;
  logic [2:0]  dbg_state;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .stall(stall), .memWrite(memWrite), .memRead(memRead),
    .address(address), .writeData(writeData), .readData(readData),
    .dbg_state(dbg_state)
  );

  // ---------------- data memory model ----------------
  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_val = 32'd0;

  always @(negedge clk) if (memRead) readData <= mem[address[5:0]];
  always @(posedge clk) begin
    if (memWrite) mem[address[5:0]] <= writeData;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] ref_mem [0:63];
  logic [32:0] exp_q[$];              // {err, data}
  int n_checks = 0;
  int n_fail   = 0;

  int          exp_lat, exp_rd, exp_wr;
  logic [31:0] exp_wdata, exp_addr;
  int          obs_lat, obs_rd, obs_wr, obs_bad, obs_wait;
  logic [31:0] obs_data, obs_wdata;
  logic        obs_err;

  // ---------------- driver tasks ----------------
  task automatic poke(input int idx, input logic [31:0] val);
    pl_idx = 6'(idx); pl_val = val; pl_en = 1'b1;
    ref_mem[idx] = val;
    @(posedge clk); #1 pl_en = 1'b0;
    @(negedge clk);
  endtask

  // Reference model: derives the expected outcome from the access rules,
  // then presents the request and records what the unit did.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    int w, shift;
    logic [7:0]  bv;
    logic [31:0] d;
    logic        e;
    w     = int'(addr[7:2]);
    shift = 8 * (3 - int'(addr[1:0]));
    bv    = 8'((ref_mem[w] >> shift) & 32'hFF);
    e     = (op > 3'd4) || ((op == OP_LW || op == OP_SW) && addr[1:0] != 2'b00);
    d     = 32'd0;
    exp_wdata = 32'd0;
    exp_addr  = addr >> 2;
    if (!e) begin
      case (op)
        OP_LW:  d = ref_mem[w];
        OP_LB:  d = (bv < 8'h80) ? {24'h000000, bv} : {24'hFFFFFF, bv};
        OP_LBU: d = {24'h000000, bv};
        OP_SW:  begin exp_wdata = wdata; ref_mem[w] = wdata; end
        default: begin
          exp_wdata = (ref_mem[w] & ~(32'hFF << shift)) | ({24'd0, wdata[7:0]} << shift);
          ref_mem[w] = exp_wdata;
        end
      endcase
    end
    exp_q.push_back({e, d});
    exp_lat = e ? 1 : (op == OP_SB) ? 3 : 2;
    exp_rd  = (!e && op != OP_SW) ? 1 : 0;
    exp_wr  = (!e && (op == OP_SW || op == OP_SB)) ? 1 : 0;

    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    obs_wait = 0;
    while (!req_ready && obs_wait < 6) begin @(negedge clk); obs_wait++; end
    @(posedge clk); #1;
    // Held valid while busy; the fields change but must be ignored.
    req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    obs_lat = 0; obs_rd = 0; obs_wr = 0; obs_bad = 0;
    obs_data = 32'd0; obs_err = 1'b0; obs_wdata = 32'd0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (memRead) obs_rd++;
      if (memWrite) begin obs_wr++; obs_wdata = writeData; end
      if (memRead && memWrite) obs_bad++;
      if (address !== exp_addr) obs_bad++;
      if (stall !== !resp_valid) obs_bad++;
      if (resp_valid) begin
        obs_lat = c; obs_data = resp_data; obs_err = resp_err;
        break;
      end
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({memRead, memWrite, resp_valid, resp_err, req_ready, stall} !== 6'b000010) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000010",
                         {memRead, memWrite, resp_valid, resp_err, req_ready, stall});
    end
    n_checks++;
    if (resp_data !== 32'd0) begin n_fail++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
    n_checks++;
    if (address !== 32'd0) begin n_fail++; $display("FAIL reset_address: got %h expected 0", address); end
    n_checks++;
    if (writeData !== 32'd0) begin n_fail++; $display("FAIL reset_writeData: got %h expected 0", writeData); end
    n_checks++;
    if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw();
    poke(2, 32'h12345678);
    issue(OP_LW, 32'd8, $urandom);
    idle();
    n_checks++;
    if (obs_data !== 32'h12345678 || obs_err !== 1'b0) begin
      n_fail++; $display("FAIL lw_data: got %h err %b expected 12345678 err 0", obs_data, obs_err);
    end
    n_checks++;
    if (obs_lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d expected 2", obs_lat); end
    n_checks++;
    if (obs_rd !== 1 || obs_wr !== 0) begin
      n_fail++; $display("FAIL lw_strobes: got rd %0d wr %0d expected rd 1 wr 0", obs_rd, obs_wr);
    end
    n_checks++;
    if (obs_bad !== 0) begin n_fail++; $display("FAIL lw_protocol: got %0d bad cycles expected 0", obs_bad); end
    exp_q.delete();
  endtask

  task automatic test_lb_lbu();
    poke(2, 32'h000000F0);
    issue(OP_LB, 32'd11, $urandom);
    idle();
    n_checks++;
    if (obs_data !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL lb_data: got %h expected fffffff0", obs_data); end
    issue(OP_LBU, 32'd11, $urandom);
    idle();
    n_checks++;
    if (obs_data !== 32'h000000F0) begin n_fail++; $display("FAIL lbu_data: got %h expected 000000f0", obs_data); end
    n_checks++;
    if (obs_lat !== 2) begin n_fail++; $display("FAIL lbu_latency: got %0d expected 2", obs_lat); end
    poke(3, 32'h8A7B6C5D);
    issue(OP_LB, 32'd12, $urandom);      // offset 0 is the top byte
    idle();
    n_checks++;
    if (obs_data !== 32'hFFFFFF8A) begin n_fail++; $display("FAIL lb_lane0: got %h expected ffffff8a", obs_data); end
    issue(OP_LB, 32'd13, $urandom);
    idle();
    n_checks++;
    if (obs_data !== 32'h0000007B) begin n_fail++; $display("FAIL lb_lane1: got %h expected 0000007b", obs_data); end
    exp_q.delete();
  endtask

  task automatic test_sb();
    poke(4, 32'hAABBCCDD);
    issue(OP_SB, 32'd17, {24'($urandom), 8'h11});
    idle();
    n_checks++;
    if (obs_wdata !== 32'hAA11CCDD) begin n_fail++; $display("FAIL sb_writeData: got %h expected aa11ccdd", obs_wdata); end
    n_checks++;
    if (obs_lat !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d expected 3", obs_lat); end
    n_checks++;
    if (obs_rd !== 1 || obs_wr !== 1) begin
      n_fail++; $display("FAIL sb_strobes: got rd %0d wr %0d expected rd 1 wr 1", obs_rd, obs_wr);
    end
    n_checks++;
    if (obs_data !== 32'd0 || obs_bad !== 0) begin
      n_fail++; $display("FAIL sb_resp: got data %h bad %0d expected 0 0", obs_data, obs_bad);
    end
    n_checks++;
    if (mem[4] !== 32'hAA11CCDD) begin n_fail++; $display("FAIL sb_mem: got %h expected aa11ccdd", mem[4]); end
    exp_q.delete();
  endtask

  task automatic test_errors();
    logic [2:0]  ops   [4] = '{OP_LW, OP_SW, 3'd5, 3'd7};
    logic [31:0] addrs [4] = '{32'd6, 32'd5, 32'd0, 32'd8};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], addrs[i], $urandom);
      idle();
      n_checks++;
      if (obs_err !== 1'b1 || obs_lat !== 1) begin
        n_fail++; $display("FAIL err_resp[%0d]: got err %b lat %0d expected err 1 lat 1", i, obs_err, obs_lat);
      end
      n_checks++;
      if (obs_rd !== 0 || obs_wr !== 0) begin
        n_fail++; $display("FAIL err_strobes[%0d]: got rd %0d wr %0d expected 0 0", i, obs_rd, obs_wr);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_sb();
    int wr_seen;
    poke(5, 32'h01020304);
    req_op = OP_SB; req_addr = 32'd22; req_wdata = 32'h77; req_valid = 1'b1;
    for (int i = 0; i < 6 && !req_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (dbg_state !== 3'd3 || memRead !== 1'b1) begin
      n_fail++; $display("FAIL rst_sb_rmw_rd: got state %0d memRead %b expected 3 1", dbg_state, memRead);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (dbg_state !== 3'd0 || req_ready !== 1'b1 || memWrite !== 1'b0) begin
      n_fail++; $display("FAIL rst_sb_after: got state %0d ready %b memWrite %b expected 0 1 0",
                         dbg_state, req_ready, memWrite);
    end
    reset = 1'b0;
    wr_seen = 0;
    repeat (4) begin @(negedge clk); if (memWrite) wr_seen++; end
    n_checks++;
    if (wr_seen !== 0) begin n_fail++; $display("FAIL rst_sb_nowrite: got %0d writes expected 0", wr_seen); end
    n_checks++;
    if (mem[5] !== 32'h01020304) begin n_fail++; $display("FAIL rst_sb_mem: got %h expected 01020304", mem[5]); end
  endtask

  task automatic test_back_to_back();
    issue(OP_SW, 32'd4, 32'hDEADBEEF);
    n_checks++;
    if (obs_wdata !== 32'hDEADBEEF || obs_lat !== 2) begin
      n_fail++; $display("FAIL b2b_sw: got wdata %h lat %0d expected deadbeef 2", obs_wdata, obs_lat);
    end
    issue(OP_LW, 32'd4, $urandom);      // presented during RESP
    idle();
    n_checks++;
    if (obs_wait !== 1) begin n_fail++; $display("FAIL b2b_accept_wait: got %0d expected 1", obs_wait); end
    n_checks++;
    if (obs_data !== 32'hDEADBEEF || obs_lat !== 2) begin
      n_fail++; $display("FAIL b2b_lw: got %h lat %0d expected deadbeef 2", obs_data, obs_lat);
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] addr;
    logic [32:0] exp;
    int r;
    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 10);
      op = (r < 10) ? 3'(r % 5) : 3'($urandom_range(5, 7));
      addr = 32'($urandom_range(0, 255));
      if ((op == OP_LW || op == OP_SW) && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      issue(op, addr, $urandom);
      exp = exp_q.pop_front();
      n_checks++;
      if (obs_err !== exp[32] || (!exp[32] && obs_data !== exp[31:0])) begin
        n_fail++; $display("FAIL rand_resp[%0d] op %0d addr %0d: got err %b data %h expected err %b data %h",
                           n, op, addr, obs_err, obs_data, exp[32], exp[31:0]);
      end
      n_checks++;
      if (obs_lat !== exp_lat || obs_rd !== exp_rd || obs_wr !== exp_wr || obs_bad !== 0) begin
        n_fail++; $display("FAIL rand_timing[%0d] op %0d: got lat %0d rd %0d wr %0d bad %0d expected %0d %0d %0d 0",
                           n, op, obs_lat, obs_rd, obs_wr, obs_bad, exp_lat, exp_rd, exp_wr);
      end
      if (exp_wr == 1) begin
        n_checks++;
        if (obs_wdata !== exp_wdata) begin
          n_fail++; $display("FAIL rand_wdata[%0d]: got %h expected %h", n, obs_wdata, exp_wdata);
        end
      end
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (mem[i] !== ref_mem[i]) begin
        n_fail++; $display("FAIL rand_mem[%0d]: got %h expected %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    test_reset();
    for (int i = 0; i < 64; i++) poke(i, $urandom);
    test_lw();
    test_lb_lbu();
    test_sb();
    test_errors();
    test_reset_mid_sb();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
